// File: rtl/div_stage_unit.sv
// div_stage_unit
// Iterative radix-2 restoring divide/remainder unit for the execute stage.
// One divide-class instruction is in flight at a time. While it runs, the
// unit publishes a stage record (register id, ready flag, data) that the
// hazard unit uses for stalling and forwarding.
//
// Ports
//   clock              posedge clock for all state
//   reset              synchronous, active-high reset
//   start              issue request, accepted only while busy=0
//   op                 0=DIV 1=DIVU 2=REM 3=REMU
//   dividend/divisor   operands, sampled on accept
//   dest_reg           destination register id, sampled on accept
//   retire             writeback consumed the result (DONE only)
//   flush              kill the in-flight operation (beats retire/start)
//   busy               high in every state except IDLE
//   result_valid       high only in DONE
//   stage_register_id  in-flight destination, 0 when idle
//   stage_data_ready   0 while computing, 1 in IDLE and DONE
//   stage_data         final result in DONE, 0 otherwise
//
// State   | meaning
// IDLE    | waiting for start
// PREP    | take magnitudes, record signs, catch div-by-zero / overflow
// ITER    | 32 shift/trial-subtract steps
// FIXUP   | pick quotient or remainder, apply sign
// DONE    | result held on the stage record until retire
module div_stage_unit #(
  parameter int WIDTH    = 32,
  parameter int REG_ID_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    dividend,
  input  logic [WIDTH-1:0]    divisor,
  input  logic [REG_ID_W-1:0] dest_reg,
  input  logic                retire,
  input  logic                flush,
  output logic                busy,
  output logic                result_valid,
  output logic [REG_ID_W-1:0] stage_register_id,
  output logic                stage_data_ready,
  output logic [WIDTH-1:0]    stage_data
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              state_q;
  logic [1:0]          op_q;
  logic [WIDTH-1:0]    dividend_q;
  logic [WIDTH-1:0]    divisor_q;
  logic [REG_ID_W-1:0] dest_q;
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    quo_q;
  logic [4:0]          cnt_q;
  logic                qsign_q;
  logic                rsign_q;
  logic                special_q;

  logic                busy_q;
  logic                result_valid_q;
  logic [REG_ID_W-1:0] stage_id_q;
  logic                stage_ready_q;
  logic [WIDTH-1:0]    stage_data_q;

  logic                op_signed_d;
  logic                dvd_neg_d;
  logic                dvs_neg_d;
  logic [WIDTH-1:0]    dvd_mag_d;
  logic [WIDTH-1:0]    dvs_mag_d;
  logic                div_zero_d;
  logic                ovf_d;
  logic [WIDTH:0]      rem_sh_d;
  logic [WIDTH:0]      trial_d;
  logic [WIDTH-1:0]    fix_sel_d;
  logic                fix_neg_d;
  logic [WIDTH-1:0]    result_d;

  always_comb begin
    op_signed_d = ~op_q[0];
    dvd_neg_d   = op_signed_d & dividend_q[WIDTH-1];
    dvs_neg_d   = op_signed_d & divisor_q[WIDTH-1];
    // Magnitude of MIN_NEG wraps to itself, which is correct read as unsigned.
    dvd_mag_d   = dvd_neg_d ? ('0 - dividend_q) : dividend_q;
    dvs_mag_d   = dvs_neg_d ? ('0 - divisor_q) : divisor_q;
    div_zero_d  = (divisor_q == '0);
    ovf_d       = op_signed_d && (dividend_q == MIN_NEG) && (divisor_q == '1);
    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shift.
    rem_sh_d    = {rem_q, quo_q[WIDTH-1]};
    trial_d     = rem_sh_d - {1'b0, divisor_q};
    fix_sel_d   = op_q[1] ? rem_q : quo_q;
    fix_neg_d   = op_signed_d & (op_q[1] ? rsign_q : qsign_q);
    if (special_q) result_d = rem_q;
    else           result_d = fix_neg_d ? ('0 - fix_sel_d) : fix_sel_d;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      stage_id_q     <= '0;
      stage_ready_q  <= 1'b1;
      stage_data_q   <= '0;
      special_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q          <= op;
            dividend_q    <= dividend;
            divisor_q     <= divisor;
            dest_q        <= dest_reg;
            state_q       <= PREP;
            busy_q        <= 1'b1;
            stage_id_q    <= dest_reg;
            stage_ready_q <= 1'b0;
          end
        end
        PREP: begin
          qsign_q   <= dvd_neg_d ^ dvs_neg_d;
          rsign_q   <= dvd_neg_d;
          quo_q     <= dvd_mag_d;
          divisor_q <= dvs_mag_d;
          cnt_q     <= 5'd31;
          // Special cases skip ITER; the preset result rides through FIXUP
          // in rem_q so every path reaches DONE through the same register.
          if (div_zero_d) begin
            special_q <= 1'b1;
            rem_q     <= op_q[1] ? dividend_q : '1;
            state_q   <= FIXUP;
          end else if (ovf_d) begin
            special_q <= 1'b1;
            rem_q     <= op_q[1] ? '0 : MIN_NEG;
            state_q   <= FIXUP;
          end else begin
            special_q <= 1'b0;
            rem_q     <= '0;
            state_q   <= ITER;
          end
        end
        ITER: begin
          rem_q <= trial_d[WIDTH] ? rem_sh_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= FIXUP;
        end
        FIXUP: begin
          stage_data_q   <= result_d;
          result_valid_q <= 1'b1;
          stage_ready_q  <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          if (retire) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            stage_id_q     <= '0;
            stage_data_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign result_valid      = result_valid_q;
  assign stage_register_id = stage_id_q;
  assign stage_data_ready  = stage_ready_q;
  assign stage_data        = stage_data_q;

endmodule

// File: tb/tb_div_stage_unit.sv
module tb_div_stage_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  dest_reg;
  logic        retire;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [4:0]  stage_register_id;
  logic        stage_data_ready;
  logic [31:0] stage_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clock = ~clock;

  div_stage_unit #(.WIDTH(32), .REG_ID_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .dest_reg(dest_reg),
    .retire(retire), .flush(flush), .busy(busy), .result_valid(result_valid),
    .stage_register_id(stage_register_id), .stage_data_ready(stage_data_ready),
    .stage_data(stage_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit push);
    op = o; dividend = a; divisor = b; dest_reg = d; start = 1'b1;
    if (push) sb_q.push_back(ref_div(o, a, b));
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [4:0] d, output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 200) begin
      chk("rec_id_busy", 32'(stage_register_id), 32'(d));
      chk("rec_ready_busy", 32'(stage_data_ready), 32'd0);
      @(negedge clock);
      n++;
    end
  endtask

  task automatic check_result(input logic [4:0] d);
    logic [31:0] exp;
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("done_ready", 32'(stage_data_ready), 32'd1);
    chk("done_id", 32'(stage_register_id), 32'(d));
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("stage_data", stage_data, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_id"}, 32'(stage_register_id), 32'd0);
    chk({tag, "_ready"}, 32'(stage_data_ready), 32'd1);
    chk({tag, "_data"}, stage_data, 32'd0);
  endtask

  task automatic do_retire();
    retire = 1'b1;
    @(negedge clock);
    retire = 1'b0;
    check_idle("retire");
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int lat);
    int n;
    issue(o, a, b, d, 1'b1);
    wait_done(d, n);
    chk("latency", 32'(n), 32'(lat));
    check_result(d);
    do_retire();
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    dest_reg = '0; retire = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_idle("reset");

    run_op(2'd0, 32'd100, 32'd7, 5'd5, 34);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 34);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd7, 34);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd8, 34);
    run_op(2'd1, 32'd1234, 32'd0, 5'd9, 2);
    run_op(2'd2, 32'd1234, 32'd0, 5'd10, 2);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 2);
    run_op(2'd0, 32'h8000_0000, 32'd3, 5'd0, 34);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 34);
    for (int i = 0; i < 4; i++)
      run_op(2'(i), $urandom, $urandom_range(1, 1000), 5'(i + 20), 34);

    // Flush ten cycles into ITER.
    issue(2'd0, 32'd5000, 32'd3, 5'd4, 1'b0);
    repeat (11) @(negedge clock);
    chk("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_idle("flush");
    run_op(2'd1, 32'd5000, 32'd3, 5'd4, 34);

    // Reset mid-ITER.
    issue(2'd2, 32'd5000, 32'd7, 5'd14, 1'b0);
    repeat (11) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("midreset");
    run_op(2'd2, 32'd5000, 32'd7, 5'd14, 34);

    // Start while busy is ignored, also in DONE and alongside retire.
    issue(2'd1, 32'd1000, 32'd10, 5'd3, 1'b1);
    repeat (5) @(negedge clock);
    op = 2'd0; dividend = 32'd77; divisor = 32'd7; dest_reg = 5'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(5'd3, n);
    chk("busy_start_latency", 32'(n), 32'd28);
    check_result(5'd3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("done_start_valid", 32'(result_valid), 32'd1);
    chk("done_start_data", stage_data, 32'd100);
    start = 1'b1; retire = 1'b1;
    @(negedge clock);
    start = 1'b0; retire = 1'b0;
    check_idle("start_retire");
    @(negedge clock);
    chk("start_retire_busy_later", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
